// File: rtl/alt_ddrx_cmd_decoder.sv
// Passive AFI command-bus decoder: per-slot field decode, bank open tracking, per-chip power state and protocol error flags.
// Optional saturating command counters are built when ALT_DDRX_CMD_DEC_CNT_EN is defined.
module alt_ddrx_cmd_decoder #(
  parameter int MEM_IF_CS_WIDTH   = 1,
  parameter int MEM_IF_ADDR_WIDTH = 13,
  parameter int MEM_IF_ROW_WIDTH  = 13,
  parameter int MEM_IF_COL_WIDTH  = 10,
  parameter int MEM_IF_BA_WIDTH   = 3,
  parameter     MEM_TYPE          = "DDR2",
  parameter int DWIDTH_RATIO      = 2
) (
  input  logic                                            ctl_clk,
  input  logic                                            ctl_reset,
  input  logic [MEM_IF_CS_WIDTH*(DWIDTH_RATIO/2)-1:0]     afi_cke,
  input  logic [MEM_IF_CS_WIDTH*(DWIDTH_RATIO/2)-1:0]     afi_cs_n,
  input  logic [(DWIDTH_RATIO/2)-1:0]                     afi_ras_n,
  input  logic [(DWIDTH_RATIO/2)-1:0]                     afi_cas_n,
  input  logic [(DWIDTH_RATIO/2)-1:0]                     afi_we_n,
  input  logic [MEM_IF_BA_WIDTH*(DWIDTH_RATIO/2)-1:0]     afi_ba,
  input  logic [MEM_IF_ADDR_WIDTH*(DWIDTH_RATIO/2)-1:0]   afi_addr,
  input  logic                                            err_clr,
  output logic                                            dec_valid,
  output logic [2:0]                                      dec_cmd,
  output logic [MEM_IF_CS_WIDTH-1:0]                      dec_chip,
  output logic [MEM_IF_BA_WIDTH-1:0]                      dec_bank,
  output logic [MEM_IF_ROW_WIDTH-1:0]                     dec_row,
  output logic [MEM_IF_COL_WIDTH-1:0]                     dec_col,
  output logic                                            dec_ap,
  output logic                                            dec_bc,
  output logic [MEM_IF_CS_WIDTH*(2**MEM_IF_BA_WIDTH)-1:0] bank_open,
  output logic [2*MEM_IF_CS_WIDTH-1:0]                    pwr_state,
  output logic [4:0]                                      err_pulse,
  output logic [4:0]                                      err_status,
  output logic [15:0]                                     cnt_act,
  output logic [15:0]                                     cnt_rd,
  output logic [15:0]                                     cnt_wr,
  output logic [15:0]                                     cnt_ref
);
  localparam int CS   = MEM_IF_CS_WIDTH;
  localparam int ADDR = MEM_IF_ADDR_WIDTH;
  localparam int ROW  = MEM_IF_ROW_WIDTH;
  localparam int COL  = MEM_IF_COL_WIDTH;
  localparam int BA   = MEM_IF_BA_WIDTH;
  localparam int P    = DWIDTH_RATIO / 2;
  localparam int NB   = 2 ** BA;
  localparam bit IS_DDR3 = (MEM_TYPE == "DDR3");
  localparam int AWX0 = (ADDR > COL + 2) ? ADDR : COL + 2;
  localparam int AWX  = (AWX0 > 13) ? AWX0 : 13;

  typedef enum logic [2:0] {
    CMD_LMR = 3'd0, CMD_REF = 3'd1, CMD_PRE = 3'd2, CMD_ACT = 3'd3,
    CMD_WR  = 3'd4, CMD_RD  = 3'd5, CMD_ZQ  = 3'd6, CMD_PREA = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    PWR_NORMAL = 2'd0, PWR_PDN = 2'd1, PWR_SRF = 2'd2
  } pwr_e;

  logic            dec_valid_q, dec_valid_d;
  cmd_e            dec_cmd_q, dec_cmd_d;
  logic [CS-1:0]   dec_chip_q, dec_chip_d;
  logic [BA-1:0]   dec_bank_q, dec_bank_d;
  logic [ROW-1:0]  dec_row_q, dec_row_d;
  logic [COL-1:0]  dec_col_q, dec_col_d;
  logic            dec_ap_q, dec_ap_d, dec_bc_q, dec_bc_d;
  logic [CS*NB-1:0] bank_open_q, bank_open_d;
  pwr_e            pwr_q [CS];
  pwr_e            pwr_d [CS];
  logic [CS-1:0]   cke_prev_q, cke_prev_d;
  logic [4:0]      err_pulse_q, err_pulse_d, err_status_q, err_status_d;

  logic [P-1:0]    ph_nonnop, ph_cmd;
  logic [2:0]      sel_raw, last_enc;
  logic [CS-1:0]   sel_cs, go_chips;
  logic [BA-1:0]   sel_ba;
  logic [ADDR-1:0] sel_addr;
  logic [AWX-1:0]  addr_x;
  logic [COL-1:0]  col_x;
  cmd_e            sel_cmd;
  int unsigned     bidx;

  // Later phases overwrite earlier ones, so the decoded slot is the last phase carrying a command.
  always_comb begin
    ph_nonnop = '0;
    ph_cmd    = '0;
    sel_raw   = 3'b111;
    sel_cs    = '0;
    sel_ba    = '0;
    sel_addr  = '0;
    for (int unsigned p = 0; p < P; p++) begin
      ph_nonnop[p] = ({afi_ras_n[p], afi_cas_n[p], afi_we_n[p]} != 3'b111) &&
                     (IS_DDR3 || ({afi_ras_n[p], afi_cas_n[p], afi_we_n[p]} != 3'b110));
      ph_cmd[p] = ph_nonnop[p] && (|(afi_cke[p*CS +: CS] & ~afi_cs_n[p*CS +: CS]));
      if (ph_cmd[p]) begin
        sel_raw  = {afi_ras_n[p], afi_cas_n[p], afi_we_n[p]};
        sel_cs   = afi_cke[p*CS +: CS] & ~afi_cs_n[p*CS +: CS];
        sel_ba   = afi_ba[p*BA +: BA];
        sel_addr = afi_addr[p*ADDR +: ADDR];
      end
    end
    last_enc = {afi_ras_n[P-1], afi_cas_n[P-1], afi_we_n[P-1]};
  end

  assign addr_x = AWX'(sel_addr);

  always_comb begin
    sel_cmd = CMD_LMR;
    case (sel_raw)
      3'b001:  sel_cmd = CMD_REF;
      3'b010:  sel_cmd = addr_x[10] ? CMD_PREA : CMD_PRE;
      3'b011:  sel_cmd = CMD_ACT;
      3'b100:  sel_cmd = CMD_WR;
      3'b101:  sel_cmd = CMD_RD;
      3'b110:  sel_cmd = CMD_ZQ;
      default: sel_cmd = CMD_LMR;
    endcase
    col_x = '0;
    for (int unsigned i = 0; i < COL; i++) begin
      if (i < 10)        col_x[i] = addr_x[i];
      else if (!IS_DDR3) col_x[i] = addr_x[i+1];
      else if (i == 10)  col_x[i] = addr_x[11];
      else               col_x[i] = addr_x[i+2];
    end
  end

  always_comb begin
    dec_valid_d = 1'b0;
    dec_cmd_d   = dec_cmd_q;
    dec_chip_d  = dec_chip_q;
    dec_bank_d  = dec_bank_q;
    dec_row_d   = dec_row_q;
    dec_col_d   = dec_col_q;
    dec_ap_d    = dec_ap_q;
    dec_bc_d    = dec_bc_q;
    bank_open_d = bank_open_q;
    cke_prev_d  = cke_prev_q;
    err_pulse_d = '0;
    go_chips    = '0;
    bidx        = 0;
    for (int unsigned c = 0; c < CS; c++) begin
      pwr_d[c] = pwr_q[c];
      go_chips[c] = sel_cs[c] && (pwr_q[c] == PWR_NORMAL);
    end
    err_pulse_d[3] = ($countones(ph_cmd) > 1);
    for (int unsigned p = 0; p < P; p++) begin
      for (int unsigned c = 0; c < CS; c++) begin
        if (!afi_cs_n[p*CS+c] && ph_nonnop[p] && (pwr_q[c] != PWR_NORMAL)) err_pulse_d[4] = 1'b1;
      end
    end

    if (|go_chips) begin
      dec_valid_d = 1'b1;
      dec_cmd_d   = sel_cmd;
      dec_chip_d  = go_chips;
      dec_bank_d  = sel_ba;
      dec_row_d   = addr_x[ROW-1:0];
      dec_col_d   = col_x;
      dec_ap_d    = (sel_cmd == CMD_RD || sel_cmd == CMD_WR) && addr_x[10];
      dec_bc_d    = IS_DDR3 && (sel_cmd == CMD_RD || sel_cmd == CMD_WR) && !addr_x[12];
      for (int unsigned c = 0; c < CS; c++) begin
        if (go_chips[c]) begin
          bidx = c * NB + int'(sel_ba);
          case (sel_cmd)
            CMD_ACT: begin
              if (bank_open_q[bidx]) err_pulse_d[0] = 1'b1;
              bank_open_d[bidx] = 1'b1;
            end
            CMD_PRE:  bank_open_d[bidx] = 1'b0;
            CMD_PREA: bank_open_d[c*NB +: NB] = '0;
            CMD_RD, CMD_WR: begin
              if (!bank_open_q[bidx]) err_pulse_d[1] = 1'b1;
              if (addr_x[10]) bank_open_d[bidx] = 1'b0;
            end
            CMD_REF: if (|bank_open_q[c*NB +: NB]) err_pulse_d[2] = 1'b1;
            default: ;
          endcase
        end
      end
    end

    // Power state follows the last phase's CKE; SRE is a falling CKE carrying a REF to that chip.
    for (int unsigned c = 0; c < CS; c++) begin
      cke_prev_d[c] = afi_cke[(P-1)*CS+c];
      case (pwr_q[c])
        PWR_NORMAL: if (cke_prev_q[c] && !afi_cke[(P-1)*CS+c]) begin
          if (!afi_cs_n[(P-1)*CS+c] && last_enc == 3'b001) begin
            pwr_d[c] = PWR_SRF;
            if (|bank_open_q[c*NB +: NB]) err_pulse_d[2] = 1'b1;
          end else begin
            pwr_d[c] = PWR_PDN;
          end
        end
        default: if (afi_cke[(P-1)*CS+c]) pwr_d[c] = PWR_NORMAL;
      endcase
    end

    err_status_d = (err_clr ? 5'b0 : err_status_q) | err_pulse_d;
  end

  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset) begin
      dec_valid_q  <= 1'b0;
      dec_cmd_q    <= CMD_LMR;
      dec_chip_q   <= '0;
      dec_bank_q   <= '0;
      dec_row_q    <= '0;
      dec_col_q    <= '0;
      dec_ap_q     <= 1'b0;
      dec_bc_q     <= 1'b0;
      bank_open_q  <= '0;
      cke_prev_q   <= '1;
      err_pulse_q  <= '0;
      err_status_q <= '0;
      for (int unsigned c = 0; c < CS; c++) pwr_q[c] <= PWR_NORMAL;
    end else begin
      dec_valid_q  <= dec_valid_d;
      dec_cmd_q    <= dec_cmd_d;
      dec_chip_q   <= dec_chip_d;
      dec_bank_q   <= dec_bank_d;
      dec_row_q    <= dec_row_d;
      dec_col_q    <= dec_col_d;
      dec_ap_q     <= dec_ap_d;
      dec_bc_q     <= dec_bc_d;
      bank_open_q  <= bank_open_d;
      cke_prev_q   <= cke_prev_d;
      err_pulse_q  <= err_pulse_d;
      err_status_q <= err_status_d;
      for (int unsigned c = 0; c < CS; c++) pwr_q[c] <= pwr_d[c];
    end
  end

  assign dec_valid  = dec_valid_q;
  assign dec_cmd    = dec_cmd_q;
  assign dec_chip   = dec_chip_q;
  assign dec_bank   = dec_bank_q;
  assign dec_row    = dec_row_q;
  assign dec_col    = dec_col_q;
  assign dec_ap     = dec_ap_q;
  assign dec_bc     = dec_bc_q;
  assign bank_open  = bank_open_q;
  assign err_pulse  = err_pulse_q;
  assign err_status = err_status_q;

  always_comb begin
    pwr_state = '0;
    for (int unsigned c = 0; c < CS; c++) pwr_state[2*c +: 2] = pwr_q[c];
  end

`ifdef ALT_DDRX_CMD_DEC_CNT_EN
  logic [15:0] cnt_act_q, cnt_act_d, cnt_rd_q, cnt_rd_d, cnt_wr_q, cnt_wr_d, cnt_ref_q, cnt_ref_d;

  always_comb begin
    cnt_act_d = cnt_act_q;
    cnt_rd_d  = cnt_rd_q;
    cnt_wr_d  = cnt_wr_q;
    cnt_ref_d = cnt_ref_q;
    if (err_clr) begin
      cnt_act_d = '0;
      cnt_rd_d  = '0;
      cnt_wr_d  = '0;
      cnt_ref_d = '0;
    end else if (dec_valid_d) begin
      case (sel_cmd)
        CMD_ACT: if (cnt_act_q != '1) cnt_act_d = cnt_act_q + 16'd1;
        CMD_RD:  if (cnt_rd_q  != '1) cnt_rd_d  = cnt_rd_q  + 16'd1;
        CMD_WR:  if (cnt_wr_q  != '1) cnt_wr_d  = cnt_wr_q  + 16'd1;
        CMD_REF: if (cnt_ref_q != '1) cnt_ref_d = cnt_ref_q + 16'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset) begin
      cnt_act_q <= '0;
      cnt_rd_q  <= '0;
      cnt_wr_q  <= '0;
      cnt_ref_q <= '0;
    end else begin
      cnt_act_q <= cnt_act_d;
      cnt_rd_q  <= cnt_rd_d;
      cnt_wr_q  <= cnt_wr_d;
      cnt_ref_q <= cnt_ref_d;
    end
  end

  assign cnt_act = cnt_act_q;
  assign cnt_rd  = cnt_rd_q;
  assign cnt_wr  = cnt_wr_q;
  assign cnt_ref = cnt_ref_q;
`else
  assign cnt_act = '0;
  assign cnt_rd  = '0;
  assign cnt_wr  = '0;
  assign cnt_ref = '0;
`endif

endmodule

// File: tb/tb_alt_ddrx_cmd_decoder.sv
// Directed bench: full-rate DDR2 single-chip vector table, plus half-rate DDR3 dual-chip sequences.
module tb_alt_ddrx_cmd_decoder;
  localparam logic [2:0] E_LMR = 3'b000, E_REF = 3'b001, E_PRE = 3'b010, E_ACT = 3'b011,
                         E_WR  = 3'b100, E_RD  = 3'b101, E_ZQ  = 3'b110, E_NOP = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Full-rate DDR2, one chip
  logic        a_cke, a_cs_n, a_ras_n, a_cas_n, a_we_n, a_clr;
  logic [2:0]  a_ba;
  logic [12:0] a_addr;
  logic        a_valid, a_chip, a_ap, a_bc;
  logic [2:0]  a_cmd, a_bank;
  logic [12:0] a_row;
  logic [9:0]  a_col;
  logic [7:0]  a_open;
  logic [1:0]  a_pwr;
  logic [4:0]  a_pulse, a_stat;
  logic [15:0] a_cnt_act, a_cnt_rd, a_cnt_wr, a_cnt_ref;

  alt_ddrx_cmd_decoder u_dut_a (
    .ctl_clk(clk), .ctl_reset(rst),
    .afi_cke(a_cke), .afi_cs_n(a_cs_n), .afi_ras_n(a_ras_n), .afi_cas_n(a_cas_n), .afi_we_n(a_we_n),
    .afi_ba(a_ba), .afi_addr(a_addr), .err_clr(a_clr),
    .dec_valid(a_valid), .dec_cmd(a_cmd), .dec_chip(a_chip), .dec_bank(a_bank), .dec_row(a_row),
    .dec_col(a_col), .dec_ap(a_ap), .dec_bc(a_bc), .bank_open(a_open), .pwr_state(a_pwr),
    .err_pulse(a_pulse), .err_status(a_stat),
    .cnt_act(a_cnt_act), .cnt_rd(a_cnt_rd), .cnt_wr(a_cnt_wr), .cnt_ref(a_cnt_ref)
  );

  // Half-rate DDR3, two chips
  logic [3:0]  b_cke, b_cs_n;
  logic [1:0]  b_ras_n, b_cas_n, b_we_n;
  logic [5:0]  b_ba;
  logic [25:0] b_addr;
  logic        b_clr;
  logic        b_valid, b_ap, b_bc;
  logic [2:0]  b_cmd, b_bank;
  logic [1:0]  b_chip;
  logic [12:0] b_row;
  logic [9:0]  b_col;
  logic [15:0] b_open;
  logic [3:0]  b_pwr;
  logic [4:0]  b_pulse, b_stat;
  logic [15:0] b_cnt_act, b_cnt_rd, b_cnt_wr, b_cnt_ref;

  alt_ddrx_cmd_decoder #(.MEM_IF_CS_WIDTH(2), .MEM_TYPE("DDR3"), .DWIDTH_RATIO(4)) u_dut_b (
    .ctl_clk(clk), .ctl_reset(rst),
    .afi_cke(b_cke), .afi_cs_n(b_cs_n), .afi_ras_n(b_ras_n), .afi_cas_n(b_cas_n), .afi_we_n(b_we_n),
    .afi_ba(b_ba), .afi_addr(b_addr), .err_clr(b_clr),
    .dec_valid(b_valid), .dec_cmd(b_cmd), .dec_chip(b_chip), .dec_bank(b_bank), .dec_row(b_row),
    .dec_col(b_col), .dec_ap(b_ap), .dec_bc(b_bc), .bank_open(b_open), .pwr_state(b_pwr),
    .err_pulse(b_pulse), .err_status(b_stat),
    .cnt_act(b_cnt_act), .cnt_rd(b_cnt_rd), .cnt_wr(b_cnt_wr), .cnt_ref(b_cnt_ref)
  );

  typedef struct {
    logic        cke, cs_n;
    logic [2:0]  enc, ba;
    logic [12:0] addr;
    logic        clr, ev;
    logic [2:0]  ecmd, ebank;
    logic [12:0] erow;
    logic [9:0]  ecol;
    logic        eap;
    logic [7:0]  eopen;
    logic [1:0]  epwr;
    logic [4:0]  epulse, estat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int cke, input int cs_n, input logic [2:0] enc, input int ba,
                              input int addr, input int clr, input int ev, input int cmd, input int bank,
                              input int row, input int col, input int ap, input int open, input int pwr,
                              input int pulse, input int stat);
    vec_t v;
    v.cke = 1'(cke);  v.cs_n = 1'(cs_n); v.enc = enc; v.ba = 3'(ba); v.addr = 13'(addr);
    v.clr = 1'(clr);  v.ev = 1'(ev); v.ecmd = 3'(cmd); v.ebank = 3'(bank); v.erow = 13'(row);
    v.ecol = 10'(col); v.eap = 1'(ap); v.eopen = 8'(open); v.epwr = 2'(pwr);
    v.epulse = 5'(pulse); v.estat = 5'(stat);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_a();
    a_cke = 1'b1; a_cs_n = 1'b1; {a_ras_n, a_cas_n, a_we_n} = E_NOP;
    a_ba = '0; a_addr = '0; a_clr = 1'b0;
  endtask

  task automatic set_b(input int p, input logic [1:0] cke, input logic [1:0] csn, input logic [2:0] enc,
                       input logic [2:0] ba, input logic [12:0] addr);
    b_cke[p*2 +: 2] = cke; b_cs_n[p*2 +: 2] = csn;
    b_ras_n[p] = enc[2]; b_cas_n[p] = enc[1]; b_we_n[p] = enc[0];
    b_ba[p*3 +: 3] = ba; b_addr[p*13 +: 13] = addr;
  endtask

  task automatic idle_b();
    set_b(0, 2'b11, 2'b11, E_NOP, 3'd0, 13'd0);
    set_b(1, 2'b11, 2'b11, E_NOP, 3'd0, 13'd0);
    b_clr = 1'b0;
  endtask

  task automatic chk_b(input string t, input int ev, input int cmd, input int chip, input int bank,
                       input int row, input int col, input int ap, input int bc, input int open,
                       input int pulse, input int stat);
    chk({t, " valid"}, 32'(b_valid), 32'(ev));
    if (ev != 0) begin
      chk({t, " cmd"},  32'(b_cmd),  32'(cmd));
      chk({t, " chip"}, 32'(b_chip), 32'(chip));
      chk({t, " bank"}, 32'(b_bank), 32'(bank));
      chk({t, " row"},  32'(b_row),  32'(row));
      chk({t, " col"},  32'(b_col),  32'(col));
      chk({t, " ap"},   32'(b_ap),   32'(ap));
      chk({t, " bc"},   32'(b_bc),   32'(bc));
    end
    chk({t, " open"},  32'(b_open),  32'(open));
    chk({t, " pulse"}, 32'(b_pulse), 32'(pulse));
    chk({t, " stat"},  32'(b_stat),  32'(stat));
  endtask

  initial begin
    idle_a();
    idle_b();

    //   cke cs  enc    ba addr     clr ev cmd bk row      col      ap open  pwr pulse stat
    add(1, 0, E_ACT, 2, 'h1A5, 0,  1, 3, 2, 'h1A5, 'h1A5, 0, 'h04, 0, 'h00, 'h00);
    add(1, 0, E_RD,  2, 'h7F0, 0,  1, 5, 2, 'h7F0, 'h3F0, 1, 'h00, 0, 'h00, 'h00);
    add(1, 1, E_NOP, 0, 'h000, 0,  0, 0, 0, 0,     0,     0, 'h00, 0, 'h00, 'h00);
    add(1, 0, E_ACT, 1, 'h010, 0,  1, 3, 1, 'h010, 'h010, 0, 'h02, 0, 'h00, 'h00);
    add(1, 0, E_ACT, 1, 'h020, 0,  1, 3, 1, 'h020, 'h020, 0, 'h02, 0, 'h01, 'h01);
    add(1, 1, E_NOP, 0, 'h000, 0,  0, 0, 0, 0,     0,     0, 'h02, 0, 'h00, 'h01);
    add(1, 1, E_NOP, 0, 'h000, 1,  0, 0, 0, 0,     0,     0, 'h02, 0, 'h00, 'h00);
    add(1, 0, E_ACT, 0, 'h005, 0,  1, 3, 0, 'h005, 'h005, 0, 'h03, 0, 'h00, 'h00);
    add(1, 0, E_ACT, 3, 'h006, 0,  1, 3, 3, 'h006, 'h006, 0, 'h0B, 0, 'h00, 'h00);
    add(1, 0, E_WR,  4, 'h008, 0,  1, 4, 4, 'h008, 'h008, 0, 'h0B, 0, 'h02, 'h02);
    add(1, 0, E_PRE, 0, 'h400, 0,  1, 7, 0, 'h400, 'h000, 0, 'h00, 0, 'h00, 'h02);
    add(1, 1, E_NOP, 0, 'h000, 1,  0, 0, 0, 0,     0,     0, 'h00, 0, 'h00, 'h00);
    add(1, 0, E_ACT, 5, 'h033, 0,  1, 3, 5, 'h033, 'h033, 0, 'h20, 0, 'h00, 'h00);
    add(1, 0, E_ACT, 5, 'h034, 1,  1, 3, 5, 'h034, 'h034, 0, 'h20, 0, 'h01, 'h01);
    add(1, 1, E_NOP, 0, 'h000, 0,  0, 0, 0, 0,     0,     0, 'h20, 0, 'h00, 'h01);
    add(1, 1, E_NOP, 0, 'h000, 1,  0, 0, 0, 0,     0,     0, 'h20, 0, 'h00, 'h00);
    add(1, 0, E_PRE, 5, 'h000, 0,  1, 2, 5, 'h000, 'h000, 0, 'h00, 0, 'h00, 'h00);
    add(1, 0, E_ACT, 6, 'h077, 0,  1, 3, 6, 'h077, 'h077, 0, 'h40, 0, 'h00, 'h00);
    add(1, 0, E_REF, 0, 'h000, 0,  1, 1, 0, 'h000, 'h000, 0, 'h40, 0, 'h04, 'h04);
    add(1, 0, E_PRE, 0, 'h400, 0,  1, 7, 0, 'h400, 'h000, 0, 'h00, 0, 'h00, 'h04);
    add(1, 1, E_NOP, 0, 'h000, 1,  0, 0, 0, 0,     0,     0, 'h00, 0, 'h00, 'h00);
    // self-refresh entry, 10-cycle hold with an illegal ACT, then exit
    add(0, 0, E_REF, 0, 'h000, 0,  0, 0, 0, 0,     0,     0, 'h00, 2, 'h00, 'h00);
    for (int k = 0; k < 3; k++)
      add(0, 1, E_NOP, 0, 'h000, 0, 0, 0, 0, 0,    0,     0, 'h00, 2, 'h00, 'h00);
    add(0, 0, E_ACT, 1, 'h011, 0,  0, 0, 0, 0,     0,     0, 'h00, 2, 'h10, 'h10);
    for (int k = 0; k < 5; k++)
      add(0, 1, E_NOP, 0, 'h000, 0, 0, 0, 0, 0,    0,     0, 'h00, 2, 'h00, 'h10);
    add(1, 1, E_NOP, 0, 'h000, 0,  0, 0, 0, 0,     0,     0, 'h00, 0, 'h00, 'h10);
    add(1, 1, E_NOP, 0, 'h000, 1,  0, 0, 0, 0,     0,     0, 'h00, 0, 'h00, 'h00);
    // power-down entry and exit
    add(0, 1, E_NOP, 0, 'h000, 0,  0, 0, 0, 0,     0,     0, 'h00, 1, 'h00, 'h00);
    add(0, 1, E_NOP, 0, 'h000, 0,  0, 0, 0, 0,     0,     0, 'h00, 1, 'h00, 'h00);
    add(1, 1, E_NOP, 0, 'h000, 0,  0, 0, 0, 0,     0,     0, 'h00, 0, 'h00, 'h00);
    add(1, 0, E_ACT, 7, 'h1FF, 0,  1, 3, 7, 'h1FF, 'h1FF, 0, 'h80, 0, 'h00, 'h00);
    add(1, 0, E_PRE, 7, 'h000, 0,  1, 2, 7, 'h000, 'h000, 0, 'h00, 0, 'h00, 'h00);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst a valid", 32'(a_valid), 0);
    chk("rst a open",  32'(a_open),  0);
    chk("rst a pwr",   32'(a_pwr),   0);
    chk("rst a pulse", 32'(a_pulse), 0);
    chk("rst a stat",  32'(a_stat),  0);
    chk("rst b open",  32'(b_open),  0);
    chk("rst b pwr",   32'(b_pwr),   0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      a_cke = vecs[i].cke; a_cs_n = vecs[i].cs_n; {a_ras_n, a_cas_n, a_we_n} = vecs[i].enc;
      a_ba = vecs[i].ba; a_addr = vecs[i].addr; a_clr = vecs[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valid", i), 32'(a_valid), 32'(vecs[i].ev));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d cmd", i),  32'(a_cmd),  32'(vecs[i].ecmd));
        chk($sformatf("v%0d chip", i), 32'(a_chip), 1);
        chk($sformatf("v%0d bank", i), 32'(a_bank), 32'(vecs[i].ebank));
        chk($sformatf("v%0d row", i),  32'(a_row),  32'(vecs[i].erow));
        chk($sformatf("v%0d col", i),  32'(a_col),  32'(vecs[i].ecol));
        chk($sformatf("v%0d ap", i),   32'(a_ap),   32'(vecs[i].eap));
        chk($sformatf("v%0d bc", i),   32'(a_bc),   0);
      end
      chk($sformatf("v%0d open", i),  32'(a_open),  32'(vecs[i].eopen));
      chk($sformatf("v%0d pwr", i),   32'(a_pwr),   32'(vecs[i].epwr));
      chk($sformatf("v%0d pulse", i), 32'(a_pulse), 32'(vecs[i].epulse));
      chk($sformatf("v%0d stat", i),  32'(a_stat),  32'(vecs[i].estat));
    end
    idle_a();

    // Half rate: commands in both phases, only phase 1 is decoded
    set_b(0, 2'b11, 2'b10, E_ACT, 3'd1, 13'h055);
    set_b(1, 2'b11, 2'b10, E_ACT, 3'd2, 13'h0AA);
    @(posedge clk); #1;
    chk_b("hr both", 1, 3, 'b01, 2, 'h0AA, 'h0AA, 0, 0, 'h0004, 'h08, 'h08);
    set_b(0, 2'b11, 2'b11, E_NOP, 3'd0, 13'h000);
    set_b(1, 2'b11, 2'b10, E_RD,  3'd2, 13'h012);
    @(posedge clk); #1;
    chk_b("hr rd bc", 1, 5, 'b01, 2, 'h012, 'h012, 0, 1, 'h0004, 'h00, 'h08);
    set_b(0, 2'b11, 2'b00, E_ACT, 3'd3, 13'h100);
    set_b(1, 2'b11, 2'b11, E_NOP, 3'd0, 13'h000);
    @(posedge clk); #1;
    chk_b("hr act 2chip", 1, 3, 'b11, 3, 'h100, 'h100, 0, 0, 'h080C, 'h00, 'h08);
    set_b(0, 2'b11, 2'b01, E_RD,  3'd3, 13'h1404);
    @(posedge clk); #1;
    chk_b("hr rd ap", 1, 5, 'b10, 3, 'h1404, 'h004, 1, 0, 'h000C, 'h00, 'h08);
    set_b(0, 2'b11, 2'b11, E_NOP, 3'd0, 13'h000);
    set_b(1, 2'b11, 2'b01, E_ZQ,  3'd0, 13'h000);
    @(posedge clk); #1;
    chk_b("hr zq", 1, 6, 'b10, 0, 0, 0, 0, 0, 'h000C, 'h00, 'h08);
    idle_b();
    @(posedge clk); #1;
    chk_b("hr idle", 0, 0, 0, 0, 0, 0, 0, 0, 'h000C, 'h00, 'h08);

    // Reset mid-traffic discards bank state
    rst = 1'b1;
    #2;
    chk("midrst b open", 32'(b_open), 0);
    chk("midrst b stat", 32'(b_stat), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_b(1, 2'b11, 2'b10, E_ACT, 3'd2, 13'h003);
    @(posedge clk); #1;
    chk_b("post rst act", 1, 3, 'b01, 2, 'h003, 'h003, 0, 0, 'h0004, 'h00, 'h00);
    idle_b();

`ifdef ALT_DDRX_CMD_DEC_CNT_EN
    a_cs_n = 1'b0; {a_ras_n, a_cas_n, a_we_n} = E_RD;
    repeat (70000) @(posedge clk);
    #1;
    chk("cnt_rd sat", 32'(a_cnt_rd), 'hFFFF);
    idle_a();
    a_clr = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0;
    chk("cnt_rd clr", 32'(a_cnt_rd), 0);
`else
    chk("cnt_act off", 32'(a_cnt_act), 0);
    chk("cnt_rd off",  32'(a_cnt_rd),  0);
    chk("cnt_wr off",  32'(a_cnt_wr),  0);
    chk("cnt_ref off", 32'(a_cnt_ref), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
